// File: rtl/dma_tx_sched.sv
// Round-robin TX scheduler: grants one channel at a time for up to quantum packets per turn.
// Optional stall timeout with sticky per-channel error flags is enabled by DMA_TX_SCHED_TIMEOUT_EN.
module dma_tx_sched #(
    parameter int N      = 4,
    parameter int QW     = 4,
    parameter int TO_CYC = 255
) (
    input  logic                   user_clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N*QW-1:0]        quantum,
    input  logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic                   tx_last,
    input  logic                   err_clr,
    output logic [N-1:0]           grant,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   busy,
    output logic [N-1:0]           to_err
);

    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n, cur, cur_n, cur_inc;
    logic [IW-1:0]   sel, sel_off;
    logic [IW:0]     sel_sum;
    logic            sel_found;
    logic [2*N-1:0]  req_rot;
    logic [QW-1:0]   credit, credit_n, q_sel;
    logic            pkt_open, pkt_open_n;
    logic [N-1:0]    grant_n;
    logic [IW-1:0]   grant_id_n;
    logic            acc, pkt_end, done;
    logic            stall_hit, timeout_hit;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        if (int'(i) == N - 1) return '0;
        return i + IW'(1);
    endfunction

    assign acc     = (state == BURST) && tx_valid && tx_ready;
    assign pkt_end = acc && tx_last;
    assign busy    = (state == BURST);
    assign cur_inc = wrap_inc(cur);

    // Rotate req so the search starts at ptr; the lowest set bit of the rotated vector wins.
    assign req_rot = {req, req} >> ptr;

    always_comb begin
        sel_off   = '0;
        sel_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel_off   = IW'(i);
                sel_found = 1'b1;
            end
        end
        sel_sum = {1'b0, ptr} + {1'b0, sel_off};
        if (sel_sum >= (IW+1)'(N)) sel_sum = sel_sum - (IW+1)'(N);
        sel   = sel_sum[IW-1:0];
        q_sel = quantum[sel*QW +: QW];
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cur_n       = cur;
        credit_n    = credit;
        pkt_open_n  = pkt_open;
        grant_n     = grant;
        grant_id_n  = grant_id;
        done        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_n    = BURST;
                    cur_n      = sel;
                    credit_n   = (q_sel == '0) ? QW'(1) : q_sel;
                    pkt_open_n = 1'b0;
                    grant_n    = N'(1) << sel;
                    grant_id_n = sel;
                end
            end
            BURST: begin
                if (pkt_end) begin
                    credit_n   = credit - QW'(1);
                    pkt_open_n = 1'b0;
                    done       = (credit_n == '0) || !req[cur];
                end else if (acc) begin
                    pkt_open_n = 1'b1;
                end else if (!pkt_open && !req[cur]) begin
                    done = 1'b1;
                end else if (stall_hit) begin
                    timeout_hit = 1'b1;
                    done        = 1'b1;
                end
                if (done) begin
                    state_n    = IDLE;
                    ptr_n      = cur_inc;
                    pkt_open_n = 1'b0;
                    grant_n    = '0;
                    grant_id_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            cur      <= '0;
            credit   <= '0;
            pkt_open <= 1'b0;
            grant    <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cur      <= cur_n;
            credit   <= credit_n;
            pkt_open <= pkt_open_n;
            grant    <= grant_n;
            grant_id <= grant_id_n;
        end
    end

`ifdef DMA_TX_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TO_CYC);

    logic [15:0]  stall_cnt, stall_inc;
    logic [N-1:0] err_set;

    assign stall_inc = stall_cnt + 16'd1;
    assign stall_hit = (stall_inc == TO_LIM);
    assign err_set   = timeout_hit ? (N'(1) << cur) : '0;

    // A timeout in the same cycle as err_clr survives the clear.
    always_ff @(posedge user_clk) begin
        if (reset) begin
            stall_cnt <= '0;
            to_err    <= '0;
        end else begin
            stall_cnt <= (state == BURST && state_n == BURST && !acc) ? stall_inc : '0;
            to_err    <= (err_clr ? '0 : to_err) | err_set;
        end
    end
`else
    logic unused_cfg;

    assign stall_hit  = 1'b0;
    assign to_err     = '0;
    assign unused_cfg = err_clr | timeout_hit | (TO_CYC == 0);
`endif

endmodule

// File: tb/tb_dma_tx_sched.sv
// Self-checking bench for dma_tx_sched: vector table, directed corner sequences and
// randomized traffic compared against a behavioural scheduler model.
module tb_dma_tx_sched;

    localparam int N  = 4;
    localparam int QW = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset, tx_valid, tx_ready, tx_last, err_clr;
    logic [N-1:0]    req;
    logic [N*QW-1:0] quantum;
    logic [N-1:0]    grant, to_err;
    logic [1:0]      grant_id;
    logic            busy;

    always #5 clk = ~clk;

    dma_tx_sched #(.N(N), .QW(QW), .TO_CYC(TO)) dut (
        .user_clk (clk),
        .reset    (reset),
        .req      (req),
        .quantum  (quantum),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .err_clr  (err_clr),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .to_err   (to_err)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit           m_busy;
    int           m_cur, m_ptr, m_credit, m_stall;
    bit           m_open;
    bit [N-1:0]   m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit         acc;
        bit         done;
        bit [N-1:0] eset;
        done = 0;
        eset = '0;
        if (reset) begin
            m_busy = 0; m_ptr = 0; m_cur = 0; m_credit = 0;
            m_open = 0; m_stall = 0; m_err = '0;
            return;
        end
        if (!m_busy) begin
            if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (req[c]) begin
                        m_cur = c;
                        break;
                    end
                end
                m_credit = int'(quantum[m_cur*QW +: QW]);
                if (m_credit == 0) m_credit = 1;
                m_busy  = 1;
                m_open  = 0;
                m_stall = 0;
            end
        end else begin
            acc = tx_valid && tx_ready;
            if (acc && tx_last) begin
                m_credit--;
                m_open  = 0;
                m_stall = 0;
                done    = (m_credit == 0) || !req[m_cur];
            end else if (acc) begin
                m_open  = 1;
                m_stall = 0;
            end else if (!m_open && !req[m_cur]) begin
                done = 1;
            end
`ifdef DMA_TX_SCHED_TIMEOUT_EN
            else begin
                m_stall++;
                if (m_stall == TO) begin
                    eset[m_cur] = 1'b1;
                    done = 1;
                end
            end
`endif
            if (done) begin
                m_busy  = 0;
                m_ptr   = (m_cur + 1) % N;
                m_open  = 0;
                m_stall = 0;
            end
        end
`ifdef DMA_TX_SCHED_TIMEOUT_EN
        if (err_clr) m_err = '0;
`endif
        m_err |= eset;
    endtask

    task automatic tick(input string tag);
        logic [N-1:0] eg;
        model_step();
        @(posedge clk);
        #1;
        eg = m_busy ? (N'(1) << m_cur) : '0;
        chk({tag, ".grant"}, grant, eg);
        chk({tag, ".grant_id"}, grant_id, m_busy ? m_cur : 0);
        chk({tag, ".busy"}, busy, m_busy);
        chk({tag, ".to_err"}, to_err, m_err);
        chk({tag, ".onehot"}, ($countones(grant) <= 1), 1);
    endtask

    task automatic drive(input bit v, input bit r, input bit l);
        tx_valid = v;
        tx_ready = r;
        tx_last  = l;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0);
        tick("rst");
        reset = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [15:0] q;
        bit         v, r, l;
        logic [3:0] eg;
        logic [1:0] eid;
        bit         eb;
    } vec_t;

    vec_t tbl[11];

    initial begin
        reset = 1'b1; req = '0; quantum = '0; err_clr = 1'b0;
        drive(0, 0, 0);

        // Round-robin fairness with one-packet quanta and a dead cycle between grants
        tbl[0]  = '{1, 4'b0000, 16'h1111, 0, 0, 0, 4'b0000, 2'd0, 0};
        tbl[1]  = '{0, 4'b1111, 16'h1111, 0, 0, 0, 4'b0001, 2'd0, 1};
        tbl[2]  = '{0, 4'b1111, 16'h1111, 1, 1, 1, 4'b0000, 2'd0, 0};
        tbl[3]  = '{0, 4'b1111, 16'h1111, 0, 0, 0, 4'b0010, 2'd1, 1};
        tbl[4]  = '{0, 4'b1111, 16'h1111, 1, 1, 1, 4'b0000, 2'd0, 0};
        tbl[5]  = '{0, 4'b1111, 16'h1111, 0, 0, 0, 4'b0100, 2'd2, 1};
        tbl[6]  = '{0, 4'b1111, 16'h1111, 1, 1, 1, 4'b0000, 2'd0, 0};
        tbl[7]  = '{0, 4'b1111, 16'h1111, 0, 0, 0, 4'b1000, 2'd3, 1};
        tbl[8]  = '{0, 4'b1111, 16'h1111, 1, 1, 1, 4'b0000, 2'd0, 0};
        tbl[9]  = '{0, 4'b1111, 16'h1111, 0, 0, 0, 4'b0001, 2'd0, 1};
        tbl[10] = '{0, 4'b1111, 16'h1111, 1, 1, 1, 4'b0000, 2'd0, 0};

        for (int i = 0; i < 11; i++) begin
            reset   = tbl[i].rst;
            req     = tbl[i].req;
            quantum = tbl[i].q;
            drive(tbl[i].v, tbl[i].r, tbl[i].l);
            tick("tbl");
            chk($sformatf("tbl[%0d].grant", i), grant, tbl[i].eg);
            chk($sformatf("tbl[%0d].grant_id", i), grant_id, tbl[i].eid);
            chk($sformatf("tbl[%0d].busy", i), busy, tbl[i].eb);
        end

        // Quantum of 3 on ch1, five 2-beat packets
        do_reset();
        req = 4'b0010; quantum = 16'h0030;
        drive(0, 0, 0); tick("q.arb");
        chk("q.first_grant", grant, 4'b0010);
        for (int p = 0; p < 5; p++) begin
            drive(1, 1, 0); tick("q.beat");
            chk($sformatf("q.mid[%0d]", p), grant, 4'b0010);
            drive(1, 1, 1); tick("q.last");
            if (p == 2) begin
                chk("q.release", grant, 4'b0000);
                drive(0, 0, 0); tick("q.regrant");
                chk("q.regrant", grant, 4'b0010);
            end else begin
                chk($sformatf("q.hold[%0d]", p), grant, 4'b0010);
            end
        end
        req = 4'b0000; drive(0, 0, 0); tick("q.drop");
        chk("q.drop_idle", grant, 4'b0000);

        // req[ch2] drops mid-packet: grant held through tx_last, then ptr=3
        do_reset();
        req = 4'b0100; quantum = 16'h0000;
        drive(0, 0, 0); tick("md.arb");
        chk("md.grant", grant, 4'b0100);
        drive(1, 1, 0); tick("md.b1");
        req = 4'b0000;
        drive(1, 1, 0); tick("md.b2");
        chk("md.hold_b2", grant, 4'b0100);
        drive(0, 1, 0); tick("md.stall");
        chk("md.hold_stall", grant, 4'b0100);
        drive(1, 1, 0); tick("md.b3");
        drive(1, 1, 1); tick("md.b4");
        chk("md.released", grant, 4'b0000);
        req = 4'b1111; drive(0, 0, 0); tick("md.ptr");
        chk("md.ptr3", grant, 4'b1000);

        // Wrap from ptr=3 with zero quantum on ch3
        do_reset();
        req = 4'b0100; quantum = 16'h0000;
        drive(0, 0, 0); tick("w.arb");
        req = 4'b1001;
        drive(1, 1, 1); tick("w.end2");
        chk("w.dead1", grant, 4'b0000);
        drive(0, 0, 0); tick("w.g3");
        chk("w.grant3", grant, 4'b1000);
        drive(1, 1, 1); tick("w.end3");
        chk("w.dead2", grant, 4'b0000);
        drive(0, 0, 0); tick("w.g0");
        chk("w.grant0", grant, 4'b0001);
        drive(1, 1, 1); tick("w.end0");

        // Reset while ch1 holds an open packet
        do_reset();
        req = 4'b0010;
        drive(0, 0, 0); tick("r.arb");
        drive(1, 1, 0); tick("r.open");
        chk("r.granted", grant, 4'b0010);
        reset = 1'b1; drive(0, 0, 0); tick("r.rst");
        chk("r.grant0", grant, 4'b0000);
        chk("r.busy0", busy, 1'b0);
        reset = 1'b0; req = 4'b1111; tick("r.ptr");
        chk("r.ptr0", grant, 4'b0001);

`ifdef DMA_TX_SCHED_TIMEOUT_EN
        // Stall timeout, then err_clr, then timeout racing err_clr
        do_reset();
        req = 4'b0001; quantum = 16'h0000;
        drive(0, 0, 0); tick("to.arb");
        for (int c = 0; c < TO - 1; c++) begin
            tick("to.stall");
            chk("to.hold", grant, 4'b0001);
        end
        tick("to.hit");
        chk("to.err", to_err, 4'b0001);
        chk("to.grant", grant, 4'b0000);
        req = 4'b0000; err_clr = 1'b1; tick("to.clr");
        chk("to.cleared", to_err, 4'b0000);
        err_clr = 1'b0;
        req = 4'b0001; tick("to.arb2");
        for (int c = 0; c < TO - 1; c++) tick("to.stall2");
        err_clr = 1'b1; tick("to.race");
        chk("to.race_wins", to_err, 4'b0001);
        req = 4'b0000; tick("to.clr2");
        chk("to.cleared2", to_err, 4'b0000);
        err_clr = 1'b0;
`else
        // Without the timeout feature a long stall holds the grant and to_err stays 0
        do_reset();
        req = 4'b0001; quantum = 16'h0000;
        drive(0, 0, 0); tick("nt.arb");
        for (int c = 0; c < 3 * TO; c++) tick("nt.stall");
        chk("nt.hold", grant, 4'b0001);
        chk("nt.err", to_err, 4'b0000);
        err_clr = 1'b1; tick("nt.clr");
        chk("nt.err_clr", to_err, 4'b0000);
        err_clr = 1'b0;
`endif

        // Randomized traffic against the model
        do_reset();
        quantum = 16'h2130;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int b = 0; b < N; b++) req[b] = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 19) == 0) quantum = 16'($urandom);
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
